// File: rtl/coef_bank_pkg.sv
// Shared types and constants for the coefficient bank.
//   state_e  : commit FSM states (IDLE / CHECK / ARMED)
//   root_t   : one complex root {re, im} at the default component width
//   idx_w()  : slot-index width for a given bank depth
package coef_bank_pkg;

    localparam int unsigned DEF_N_ROOTS = 4;
    localparam int unsigned DEF_CW      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    typedef struct packed {
        logic signed [DEF_CW-1:0] re;
        logic signed [DEF_CW-1:0] im;
    } root_t;

    // Index width, kept at least 1 bit so a single-root bank still has a port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coef_bank_if.sv
// Coefficient bank bus: shadow write port, commit control and bank outputs.
//   master : writer / controller side
//   slave  : coef_bank side
interface coef_bank_if #(
    parameter int unsigned N_ROOTS = coef_bank_pkg::DEF_N_ROOTS,
    parameter int unsigned CW      = coef_bank_pkg::DEF_CW
);
    localparam int unsigned IW = coef_bank_pkg::idx_w(N_ROOTS);
    localparam int unsigned RW = 2 * CW;

    logic                         wr_valid;
    logic                         wr_ready;
    logic                         wr_sel;
    logic [IW-1:0]                wr_idx;
    logic [RW-1:0]                wr_data;
    logic                         commit_req;
    logic                         commit_cancel;
    logic                         frame_done;
    logic [N_ROOTS-1:0][RW-1:0]   zero_out;
    logic [N_ROOTS-1:0][RW-1:0]   pole_out;
    logic                         commit_pending;
    logic                         swap_pulse;
    logic                         commit_reject;

    modport master (
        output wr_valid, wr_sel, wr_idx, wr_data,
        output commit_req, commit_cancel, frame_done,
        input  wr_ready, zero_out, pole_out,
        input  commit_pending, swap_pulse, commit_reject
    );

    modport slave (
        input  wr_valid, wr_sel, wr_idx, wr_data,
        input  commit_req, commit_cancel, frame_done,
        output wr_ready, zero_out, pole_out,
        output commit_pending, swap_pulse, commit_reject
    );

endinterface

// File: rtl/coef_stab_check.sv
// Combinational pole stability test: a root passes when re^2 + im^2 < 2^(2*CW-2),
// i.e. its magnitude is strictly inside the unit circle in Q1.(CW-1).
//   root_i   : {re, im}, signed components of CW bits
//   pass_c_o : 1 when the root is stable
module coef_stab_check #(
    parameter int unsigned CW = 16
) (
    input  logic [2*CW-1:0] root_i,
    output logic            pass_c_o
);

    localparam int unsigned PW = 2 * CW + 1;
    localparam logic signed [PW-1:0] LIMIT = {2'b00, 1'b1, {(2*CW-2){1'b0}}};

    logic signed [CW-1:0] re;
    logic signed [CW-1:0] im;
    logic signed [PW-1:0] re_sq;
    logic signed [PW-1:0] im_sq;
    logic signed [PW-1:0] mag_sq;

    // Full-width products: (-1.0)^2 and the sum of two near-unity squares fit in PW bits.
    always_comb begin
        re       = root_i[2*CW-1:CW];
        im       = root_i[CW-1:0];
        re_sq    = PW'(re) * PW'(re);
        im_sq    = PW'(im) * PW'(im);
        mag_sq   = re_sq + im_sq;
        pass_c_o = (mag_sq < LIMIT);
    end

endmodule

// File: rtl/coef_bank.sv
// Double-buffered zero/pole coefficient bank. Writes land in a shadow bank;
// a commit arms the shadow (optionally after a per-pole stability check) and
// the next frame boundary copies it into the active bank driven on the outputs.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : wr_valid/wr_ready/wr_sel/wr_idx/wr_data shadow write,
//                  commit_req/commit_cancel/frame_done control,
//                  zero_out/pole_out active bank, commit_pending/swap_pulse/commit_reject status
// Build option: define COEF_BANK_STAB_CHECK_EN to add the CHECK state and pole checker.
module coef_bank
    import coef_bank_pkg::*;
#(
    parameter int unsigned N_ROOTS = DEF_N_ROOTS,
    parameter int unsigned CW      = DEF_CW
) (
    input  logic       clk,
    input  logic       reset_n,
    coef_bank_if.slave bus
);

    localparam int unsigned IW = idx_w(N_ROOTS);
    localparam int unsigned RW = 2 * CW;

    state_e                     state_q, state_d;
    logic [N_ROOTS-1:0][RW-1:0] sh_zero_q, sh_pole_q;
    logic [N_ROOTS-1:0][RW-1:0] act_zero_q, act_pole_q;
    logic                       swap_now_q;
    logic                       swap_pulse_q;

    logic                       wr_ready_c;
    logic                       pending_c;
    logic                       wr_hit_c;
    logic                       do_swap_c;

`ifdef COEF_BANK_STAB_CHECK_EN
    logic [IW-1:0]              chk_idx_q, chk_idx_d;
    logic                       pole_ok_c;
    logic                       chk_last_c;
    logic                       do_reject_c;
    logic                       reject_q;

    // One pole per cycle, walked by chk_idx_q.
    coef_stab_check #(.CW(CW)) u_stab_check (
        .root_i   (sh_pole_q[chk_idx_q]),
        .pass_c_o (pole_ok_c)
    );

    assign chk_last_c = (chk_idx_q == IW'(N_ROOTS - 1));
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; frame_done outranks commit_cancel in ARMED.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.commit_req) begin
`ifdef COEF_BANK_STAB_CHECK_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_ARMED;
`endif
                end
            end
`ifdef COEF_BANK_STAB_CHECK_EN
            ST_CHECK: begin
                if (bus.commit_cancel || !pole_ok_c) begin
                    state_d = ST_IDLE;
                end else if (chk_last_c) begin
                    state_d = ST_ARMED;
                end
            end
`endif
            ST_ARMED: begin
                if (bus.frame_done || bus.commit_cancel) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath strobes.
    always_comb begin
        wr_ready_c = (state_q == ST_IDLE);
        pending_c  = (state_q == ST_CHECK) || (state_q == ST_ARMED);
        // Out-of-range slot writes are accepted but dropped.
        wr_hit_c   = wr_ready_c && bus.wr_valid && (32'(bus.wr_idx) < N_ROOTS);
        do_swap_c  = (state_q == ST_ARMED) && bus.frame_done;
`ifdef COEF_BANK_STAB_CHECK_EN
        chk_idx_d   = '0;
        do_reject_c = 1'b0;
        if (state_q == ST_CHECK) begin
            chk_idx_d   = chk_idx_q + IW'(1);
            // A cancel in the same cycle as a failing pole suppresses the reject.
            do_reject_c = !bus.commit_cancel && !pole_ok_c;
        end
`endif
    end

    // Shadow/active banks and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_zero_q    <= '0;
            sh_pole_q    <= '0;
            act_zero_q   <= '0;
            act_pole_q   <= '0;
            swap_now_q   <= 1'b0;
            swap_pulse_q <= 1'b0;
        end else begin
            if (wr_hit_c) begin
                if (bus.wr_sel) begin
                    sh_pole_q[bus.wr_idx] <= bus.wr_data;
                end else begin
                    sh_zero_q[bus.wr_idx] <= bus.wr_data;
                end
            end
            if (do_swap_c) begin
                act_zero_q <= sh_zero_q;
                act_pole_q <= sh_pole_q;
            end
            // swap_pulse trails the active-bank update by one cycle.
            swap_now_q   <= do_swap_c;
            swap_pulse_q <= swap_now_q;
        end
    end

`ifdef COEF_BANK_STAB_CHECK_EN
    // Check index and reject pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_idx_q <= '0;
            reject_q  <= 1'b0;
        end else begin
            chk_idx_q <= chk_idx_d;
            reject_q  <= do_reject_c;
        end
    end

    assign bus.commit_reject = reject_q;
`else
    assign bus.commit_reject = 1'b0;
`endif

    assign bus.wr_ready       = wr_ready_c;
    assign bus.commit_pending = pending_c;
    assign bus.swap_pulse     = swap_pulse_q;
    assign bus.zero_out       = act_zero_q;
    assign bus.pole_out       = act_pole_q;

endmodule

// File: tb/tb_coef_bank.sv
// Bench for coef_bank: a behavioural bank model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with resets.
module tb_coef_bank;
    import coef_bank_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned RW = 2 * CW;
    localparam int unsigned N6 = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    coef_bank_if #(.N_ROOTS(N),  .CW(CW)) bus ();
    coef_bank_if #(.N_ROOTS(N6), .CW(CW)) bus6 ();

    coef_bank #(.N_ROOTS(N), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    coef_bank #(.N_ROOTS(N6), .CW(CW)) dut6 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus6.slave)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (N=4 instance) ----------------
    int          ph = 0;          // 0 idle, 1 checking, 2 armed
    int          t = 0;
    int          fail_at = -1;
    logic [RW-1:0] m_sh_z [N];
    logic [RW-1:0] m_sh_p [N];
    logic [RW-1:0] m_act_z [N];
    logic [RW-1:0] m_act_p [N];
    bit          m_swap_pend = 1'b0;
    bit          m_exp_swap = 1'b0;
    bit          m_exp_reject = 1'b0;

    function automatic int first_unstable();
        root_t  r;
        longint re, im;
        for (int i = 0; i < int'(N); i++) begin
            r  = m_sh_p[i];
            re = longint'(r.re);
            im = longint'(r.im);
            if (re * re + im * im >= (longint'(1) << (2 * CW - 2))) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        ph = 0; t = 0; fail_at = -1;
        m_swap_pend = 1'b0; m_exp_swap = 1'b0; m_exp_reject = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            m_sh_z[i] = '0; m_sh_p[i] = '0; m_act_z[i] = '0; m_act_p[i] = '0;
        end
    endtask

    task automatic model_step();
        m_exp_swap   = m_swap_pend;
        m_swap_pend  = 1'b0;
        m_exp_reject = 1'b0;
        case (ph)
            0: begin
                if (bus.wr_valid && int'(bus.wr_idx) < int'(N)) begin
                    if (bus.wr_sel) m_sh_p[int'(bus.wr_idx)] = bus.wr_data;
                    else            m_sh_z[int'(bus.wr_idx)] = bus.wr_data;
                end
                if (bus.commit_req) begin
`ifdef COEF_BANK_STAB_CHECK_EN
                    ph = 1; t = 0; fail_at = first_unstable();
`else
                    ph = 2;
`endif
                end
            end
            1: begin
                if (bus.commit_cancel) ph = 0;
                else if (fail_at == t) begin ph = 0; m_exp_reject = 1'b1; end
                else if (t == int'(N) - 1) ph = 2;
                else t++;
            end
            2: begin
                if (bus.frame_done) begin
                    for (int i = 0; i < int'(N); i++) begin
                        m_act_z[i] = m_sh_z[i]; m_act_p[i] = m_sh_p[i];
                    end
                    m_swap_pend = 1'b1;
                    ph = 0;
                end else if (bus.commit_cancel) ph = 0;
            end
            default: ph = 0;
        endcase
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // Every-cycle compare, 1 time unit after the active edge.
    always @(posedge clk) begin
        logic [N-1:0][RW-1:0] ez, ep;
        #1;
        for (int i = 0; i < int'(N); i++) begin
            ez[i] = m_act_z[i]; ep[i] = m_act_p[i];
        end
        chk("wr_ready",       256'(bus.wr_ready),       256'(ph == 0));
        chk("commit_pending", 256'(bus.commit_pending), 256'(ph != 0));
        chk("swap_pulse",     256'(bus.swap_pulse),     256'(m_exp_swap));
        chk("commit_reject",  256'(bus.commit_reject),  256'(m_exp_reject));
        chk("zero_out",       256'(bus.zero_out),       256'(ez));
        chk("pole_out",       256'(bus.pole_out),       256'(ep));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.wr_valid = 1'b0; bus.wr_sel = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
        bus.commit_req = 1'b0; bus.commit_cancel = 1'b0; bus.frame_done = 1'b0;
    endtask

    task automatic idle6();
        bus6.wr_valid = 1'b0; bus6.wr_sel = 1'b0; bus6.wr_idx = '0; bus6.wr_data = '0;
        bus6.commit_req = 1'b0; bus6.commit_cancel = 1'b0; bus6.frame_done = 1'b0;
    endtask

    task automatic wr(input bit sel, input int idx, input logic [RW-1:0] d);
        bus.wr_valid = 1'b1; bus.wr_sel = sel; bus.wr_idx = 2'(idx); bus.wr_data = d;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wr6(input bit sel, input int idx, input logic [RW-1:0] d);
        bus6.wr_valid = 1'b1; bus6.wr_sel = sel; bus6.wr_idx = 3'(idx); bus6.wr_data = d;
        step();
        bus6.wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        bus.commit_req = 1'b1;
        step();
        bus.commit_req = 1'b0;
    endtask

    task automatic pulse_frame();
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
    endtask

    function automatic logic [RW-1:0] rand_root();
        logic [13:0] a, b;
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) return r;
        a = 14'($urandom);
        b = 14'($urandom);
        return {{2{a[13]}}, a, {2{b[13]}}, b};
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [N6-1:0][RW-1:0] exp6;
        idle_in();
        idle6();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("rst_release_wr_ready", 256'(bus.wr_ready), 256'(1));
        chk("rst_pole_out",         256'(bus.pole_out), 256'(0));
        chk("rst_pending",          256'(bus.commit_pending), 256'(0));

        // Single pole write -> commit -> swap on frame_done.
        wr(1'b1, 2, 32'h2000_1000);
        pulse_commit();
        repeat (N + 1) step();
        pulse_frame();
        chk("lit_swap_pole2", 256'(bus.pole_out), 256'(128'h00000000_20001000_00000000_00000000));
        chk("lit_swap_zero",  256'(bus.zero_out), 256'(0));
        chk("lit_swap_early", 256'(bus.swap_pulse), 256'(0));
        step();
        chk("lit_swap_pulse", 256'(bus.swap_pulse), 256'(1));
        step();
        chk("lit_swap_once",  256'(bus.swap_pulse), 256'(0));

        // Unstable pole.
        wr(1'b1, 1, 32'h7FFF_7FFF);
        pulse_commit();
`ifdef COEF_BANK_STAB_CHECK_EN
        step();
        chk("lit_chk_pending", 256'(bus.commit_pending), 256'(1));
        chk("lit_chk_noreject", 256'(bus.commit_reject), 256'(0));
        step();
        chk("lit_reject",       256'(bus.commit_reject), 256'(1));
        chk("lit_reject_idle",  256'(bus.wr_ready), 256'(1));
        chk("lit_reject_act",   256'(bus.pole_out), 256'(128'h00000000_20001000_00000000_00000000));
        step();
        chk("lit_reject_once",  256'(bus.commit_reject), 256'(0));
`else
        chk("lit_nochk_armed",  256'(bus.commit_pending), 256'(1));
        chk("lit_nochk_reject", 256'(bus.commit_reject), 256'(0));
        bus.commit_cancel = 1'b1;
        step();
        bus.commit_cancel = 1'b0;
        chk("lit_cancel_idle",  256'(bus.wr_ready), 256'(1));
`endif
        wr(1'b1, 1, 32'h0000_0000);

        // Write blocked while armed; frame_done beats commit_cancel.
        wr(1'b1, 0, 32'h0100_0200);
        pulse_commit();
        repeat (N + 1) step();
        bus.wr_valid = 1'b1; bus.wr_sel = 1'b0; bus.wr_idx = 2'd3; bus.wr_data = 32'hDEAD_BEEF;
        chk("lit_armed_wr_ready", 256'(bus.wr_ready), 256'(0));
        step();
        bus.wr_valid = 1'b0;
        bus.frame_done = 1'b1; bus.commit_cancel = 1'b1;
        step();
        bus.frame_done = 1'b0; bus.commit_cancel = 1'b0;
        chk("lit_prio_pole", 256'(bus.pole_out), 256'(128'h00000000_20001000_00000000_01000200));
        chk("lit_prio_zero", 256'(bus.zero_out), 256'(0));
        step();
        chk("lit_prio_pulse", 256'(bus.swap_pulse), 256'(1));

        // frame_done together with commit_req in IDLE does not swap.
        wr(1'b0, 1, 32'h1111_2222);
        bus.frame_done = 1'b1; bus.commit_req = 1'b1;
        step();
        bus.frame_done = 1'b0; bus.commit_req = 1'b0;
        repeat (N + 1) step();
        chk("lit_idle_frame_zero", 256'(bus.zero_out), 256'(0));
        pulse_frame();
        chk("lit_next_frame_zero", 256'(bus.zero_out), 256'(128'h00000000_00000000_11112222_00000000));

        // Reset while armed aborts the commit.
        step();
        wr(1'b1, 3, 32'h0300_0300);
        pulse_commit();
        repeat (N + 1) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        pulse_frame();
        chk("lit_rst_pole", 256'(bus.pole_out), 256'(0));
        chk("lit_rst_zero", 256'(bus.zero_out), 256'(0));
        step();
        chk("lit_rst_nopulse", 256'(bus.swap_pulse), 256'(0));

        // Six-slot bank: slot 5 is valid, 6 and 7 are dropped.
        wr6(1'b1, 5, 32'h0500_0600);
        wr6(1'b1, 6, 32'hAAAA_AAAA);
        wr6(1'b0, 7, 32'hBBBB_BBBB);
        bus6.commit_req = 1'b1;
        step();
        bus6.commit_req = 1'b0;
        repeat (8) step();
        bus6.frame_done = 1'b1;
        step();
        bus6.frame_done = 1'b0;
        exp6 = '0;
        exp6[5] = 32'h0500_0600;
        chk("lit_n6_pole", 256'(bus6.pole_out), 256'(exp6));
        chk("lit_n6_zero", 256'(bus6.zero_out), 256'(0));

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bus.wr_valid      = ($urandom_range(0, 1) == 1);
            bus.wr_sel        = 1'($urandom);
            bus.wr_idx        = 2'($urandom);
            bus.wr_data       = rand_root();
            bus.commit_req    = ($urandom_range(0, 9) == 0);
            bus.commit_cancel = ($urandom_range(0, 29) == 0);
            bus.frame_done    = ($urandom_range(0, 5) == 0);
            reset_n           = ($urandom_range(0, 99) != 0);
            step();
        end
        reset_n = 1'b1;
        idle_in();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
